nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder built around one full_adder_4_bit. Accepts an operand pair
//   over a valid/ready handshake and feeds the 4-bit adder one nibble per cycle, LSB first.
//   Registers the adder's carry-out into the next nibble's carry-in and assembles the sum.
//   Returns sum, carry and signed overflow over a second valid/ready handshake.
// PARAMETERS
//   WIDTH   16   operand/sum width; multiple of 4, >= 4 (elaboration error otherwise)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept an operand pair
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_ci      in   1      carry-in for nibble 0
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  a + b + ci, modulo 2^WIDTH
//   out_co     out  1      carry-out of the top nibble
//   out_ovf    out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   - NIB = WIDTH/4. Counter width = clog2(NIB), minimum 1.
//   - States: IDLE -> RUN -> DONE -> IDLE.
//   - Reset: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_co=0, out_ovf=0, busy=0.
//     Reset dominates every other event. An in-flight add is discarded without output.
//   - IDLE: in_ready=1. in_valid=1 at a rising edge accepts the operands.
//     On accept: latch in_a and in_b into shift registers, carry<=in_ci, cnt<=0,
//     latch A/B MSBs for the overflow calculation, go to RUN.
//   - RUN: in_ready=0. Adder inputs: a=a_sh[3:0], b=b_sh[3:0], ci=carry.
//     Each edge: shift a_sh/b_sh right by 4, shift s into sum_sh[WIDTH-1 -: 4]
//     (the sum register shifts right), carry<=co, cnt++.
//     The edge with cnt==NIB-1 goes to DONE.
//   - DONE: out_valid=1. out_sum, out_co and out_ovf hold stable until
//     out_valid && out_ready; on that edge go to IDLE.
//   - Latency: out_valid rises exactly NIB edges after the accepting edge
//     (4 for WIDTH=16). Throughput: one result per NIB+2 cycles, including a
//     mandatory IDLE bubble.
//   - in_valid and all operand inputs are ignored outside IDLE. Operands are sampled only
//     on the accept edge, so later input changes have no effect.
//   - out_ready while out_valid=0 has no effect. out_valid never drops without a handshake.
//   - Wrap-around: sum is modulo 2^WIDTH. Unsigned overflow is reported only via out_co.
//   - WIDTH=4 corner case: a single RUN cycle. The design must work with cnt width 1.
// STRUCTURE
//   - Shared package nibble_serial_pkg:
//       state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//       NIBBLE=4.
//   - Sub-module: the existing full_adder_4_bit (ports a, b, ci, s, co). Instantiate it
//     once, combinationally in the datapath. No other sub-modules.
//   - All registers are in a single clocked process. The FSM's next-state logic is a
//     separate combinational block.
// TESTING  (WIDTH=16 unless stated)
//   - Case 1: a=16'h6969, b=16'h9696, ci=0 -> sum=16'hFFFF, co=0, ovf=0.
//     out_valid rises 4 edges after accept.
//   - Case 2: a=16'hFFFF, b=16'h0001, ci=0 -> sum=16'h0000, co=1, ovf=0
//     (carry ripples across all nibbles).
//   - Case 3: a=16'h7FFF, b=16'h0001, ci=0 -> sum=16'h8000, co=0, ovf=1.
//     Then a=16'h0000, b=16'h0000, ci=1 -> sum=16'h0001, co=0.
//   - Case 4: hold out_ready=0 for 5 cycles in DONE -> out_valid and the result stay stable
//     and in_ready stays 0. A new in_valid pulse meanwhile is not accepted.
//   - Case 5: assert rst on the 2nd RUN cycle -> next cycle is IDLE with all outputs at reset
//     values and no out_valid. A following add of a=16'h1234, b=16'h1111 -> sum=16'h2345.
//   - Case 6: WIDTH=4; a=4'b0110, b=4'b1011, ci=0 -> sum=4'b0001, co=1.
//     out_valid rises 1 edge after accept.

Source files
------------

// File: rtl/nibble_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_pkg
// Purpose  : Shared state encoding, nibble size and helpers for the
//            nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Nibble counter width; a single-nibble datapath still needs one bit.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_4_bit.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_4_bit
// Purpose  : Combinational 4-bit adder with carry-in and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // Widen to five bits so the carry-out falls out of the addition.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : WIDTH-bit adder that reuses one 4-bit adder, one nibble per
//            cycle LSB first, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE;
    localparam int CW  = cnt_width(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    // Reject widths that cannot be split into whole nibbles.
    generate
        if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             co_q;
    logic             ovf_q;
    logic [3:0]       fa_s;
    logic             fa_co;

    full_adder_4_bit u_fa (
        .a  (a_sh[3:0]),
        .b  (b_sh[3:0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New nibble enters at the top; the sum register shifts right.
    generate
        if (WIDTH == NIBBLE) begin : g_single_nibble
            assign sum_nx = fa_s;
        end else begin : g_multi_nibble
            assign sum_nx = {fa_s, sum_sh[WIDTH-1:NIBBLE]};
        end
    endgenerate

    // Next-state logic: accept in IDLE, run NIB nibbles, wait for the consumer.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nx = S_RUN;
            S_RUN:   if (cnt == LAST) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // All state and datapath registers; reset discards any in-flight add.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= in_ci;
                        cnt   <= '0;
                        a_msb <= in_a[WIDTH-1];
                        b_msb <= in_b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> NIBBLE;
                    b_sh   <= b_sh >> NIBBLE;
                    sum_sh <= sum_nx;
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    // The top nibble settles carry-out and the sign of the sum.
                    if (cnt == LAST) begin
                        co_q  <= fa_co;
                        ovf_q <= (a_msb == b_msb) && (fa_s[3] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign out_sum   = sum_sh;
    assign out_co    = co_q;
    assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Directed self-checking bench for nibble_serial_adder
//            (WIDTH=16 and WIDTH=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, in_ci, out_valid, out_ready, out_co, out_ovf, busy;
    logic [15:0] in_a, in_b, out_sum;

    logic        in_valid4, in_ready4, in_ci4, out_valid4, out_ready4, out_co4, out_ovf4, busy4;
    logic [3:0]  in_a4, in_b4, out_sum4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_co(out_co), .out_ovf(out_ovf), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4), .in_ci(in_ci4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
        .out_co(out_co4), .out_ovf(out_ovf4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=16 transaction; 'hold' cycles of back-pressure in DONE while
    // a competing in_valid pulse with different operands is offered.
    task automatic add16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic eco,
                         input logic eovf, input int hold);
        int edges;
        @(negedge clk);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_ci = ~ci;     // must not disturb the add
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, ".latency"}, edges, 32'd4);
        check({tag, ".sum"}, {16'd0, out_sum}, {16'd0, es});
        check({tag, ".co"}, {31'd0, out_co}, {31'd0, eco});
        check({tag, ".ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0202;
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".hold_sum"}, {16'd0, out_sum}, {16'd0, es});
            check({tag, ".hold_co"}, {31'd0, out_co}, {31'd0, eco});
            check({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    // One WIDTH=4 transaction on the second instance.
    task automatic add4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic [3:0] es, input logic eco,
                        input logic eovf);
        int edges;
        @(negedge clk);
        in_a4 = a; in_b4 = b; in_ci4 = ci; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        edges = 0;
        while (!out_valid4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, ".latency"}, edges, 32'd1);
        check({tag, ".sum"}, {28'd0, out_sum4}, {28'd0, es});
        check({tag, ".co"}, {31'd0, out_co4}, {31'd0, eco});
        check({tag, ".ovf"}, {31'd0, out_ovf4}, {31'd0, eovf});
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check({tag, ".released"}, {31'd0, out_valid4}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_ci4 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.flags", {28'd0, in_ready, out_valid, busy, out_co}, 32'h8);
        check("reset.sum", {15'd0, out_ovf, out_sum}, 32'd0);
        check("reset4.flags", {28'd0, in_ready4, out_valid4, busy4, out_co4}, 32'h8);
        rst = 1'b0;

        add16("case1", 16'h6969, 16'h9696, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
        add16("case2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        add16("case3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        add16("case3b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
        add16("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        add16("case4", 16'h1357, 16'h2468, 1'b1, 16'h37C0, 1'b0, 1'b0, 5);

        // Case 5: reset during the second RUN cycle discards the add.
        @(negedge clk);
        in_a = 16'hAAAA; in_b = 16'h5555; in_ci = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("case5.flags", {28'd0, in_ready, out_valid, busy, out_co}, 32'h8);
        check("case5.sum", {15'd0, out_ovf, out_sum}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("case5.no_valid", {31'd0, out_valid}, 32'd0);
        end
        add16("case5b", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

        add4("case6", 4'b0110, 4'b1011, 1'b0, 4'b0001, 1'b1, 1'b0);
        add4("w4ovf", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        add4("w4ci", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
